part_sync_bridge: RTL and testbench

- Parametrised partition-boundary bridge on the initiator side of a split simulation.
- Captures N_TX exported signal groups on mission-clock events and serialises them onto a single outbound link word stream.
- Collects N_RX imported groups from an inbound stream and holds each mission clock frozen until its data arrives.
- Adds per-channel freeze, round-robin export arbitration, an import timeout watchdog and sticky error flags.

---
 rtl/part_bridge_pkg.sv | 17 +
 rtl/part_rr_arb.sv | 37 +++
 rtl/part_sync_bridge.sv | 187 ++++++++++++++++++
 tb/tb_part_sync_bridge.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/part_bridge_pkg.sv
// Shared types and helpers for the partition-boundary bridge.
// Latency/backpressure: none, declarations only.
package part_bridge_pkg;

    localparam int W_DEFAULT = 9;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } fsm_e;

    // Channel-index width, never narrower than one bit.
    function automatic int chan_idx(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/part_rr_arb.sv
// Combinational N-way round-robin arbiter: grants the first request at or after ptr_i.
// Zero latency; no backpressure, the parent owns and advances the pointer.
module part_rr_arb
    import part_bridge_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]           req_i,
    input  logic [chan_idx(N)-1:0] ptr_i,
    output logic [chan_idx(N)-1:0] grant_o,
    output logic                   any_o
);

    localparam int IW = chan_idx(N);

    logic [2*N-1:0] rot;
    int             sum;

    always_comb begin
        grant_o = '0;
        any_o   = 1'b0;
        sum     = 0;
        // Rotate so bit 0 is the channel at ptr; first set bit wins.
        rot     = {req_i, req_i} >> ptr_i;
        for (int i = 0; i < N; i++) begin
            if (!any_o && rot[i]) begin
                any_o = 1'b1;
                sum   = int'(ptr_i) + i;
                if (sum >= N) begin
                    sum = sum - N;
                end
                grant_o = IW'(sum);
            end
        end
    end

endmodule

// File: rtl/part_sync_bridge.sv
// Initiator-side partition bridge: serialises exported groups onto one link, freezes mission clocks until imports arrive.
// Event to link valid in 2 cycles; words held stable until link_tx_ready_i; inbound link is never backpressured.
module part_sync_bridge
    import part_bridge_pkg::*;
#(
    parameter int N_TX = 3,
    parameter int N_RX = 1,
    parameter int W    = W_DEFAULT,
    parameter int TO_W = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_TX-1:0]           tx_evt_i,
    input  logic [N_TX*W-1:0]         tx_data_i,
    input  logic [N_RX-1:0]           rx_evt_i,
    input  logic [TO_W-1:0]           timeout_i,
    output logic                      link_tx_valid_o,
    input  logic                      link_tx_ready_i,
    output logic [chan_idx(N_TX)-1:0] link_tx_chan_o,
    output logic [W-1:0]              link_tx_data_o,
    input  logic                      link_rx_valid_i,
    input  logic [chan_idx(N_RX)-1:0] link_rx_chan_i,
    input  logic [W-1:0]              link_rx_data_i,
    output logic                      link_rx_ready_o,
    output logic [N_RX-1:0]           freeze_clk_o,
    output logic [N_RX*W-1:0]         rx_data_o,
    output logic [N_RX-1:0]           rx_upd_o,
    output logic [N_TX-1:0]           overrun_o,
    output logic                      stray_o,
    output logic [N_RX-1:0]           timeout_err_o
);

    localparam int TXC = chan_idx(N_TX);

    // Export side
    fsm_e             state_q, state_d;
    logic [TXC-1:0]   grant_q, grant_d;
    logic [TXC-1:0]   ptr_q, ptr_d;
    logic [N_TX-1:0]  pending_q, pending_d;
    logic [N_TX-1:0]  overrun_q, overrun_d;
    logic [W-1:0]     hold_q [N_TX];
    logic [W-1:0]     hold_d [N_TX];
    logic [TXC-1:0]   arb_grant;
    logic             arb_any;
    logic             tx_hs;

    part_rr_arb #(.N(N_TX)) u_arb (
        .req_i   (pending_q),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .any_o   (arb_any)
    );

    assign tx_hs = (state_q == SEND) && link_tx_ready_i;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        pending_d = pending_q;
        overrun_d = overrun_q;
        hold_d    = hold_q;
        for (int k = 0; k < N_TX; k++) begin
            if (tx_evt_i[k]) begin
                if (pending_q[k] && !(tx_hs && grant_q == TXC'(k))) begin
                    overrun_d[k] = 1'b1;
                end
                hold_d[k]    = tx_data_i[k*W +: W];
                pending_d[k] = 1'b1;
            end
        end
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (link_tx_ready_i) begin
                    // A same-cycle event on the granted channel re-arms it with the new data.
                    if (!tx_evt_i[grant_q]) begin
                        pending_d[grant_q] = 1'b0;
                    end
                    ptr_d   = (grant_q == TXC'(N_TX - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            for (int k = 0; k < N_TX; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            hold_q    <= hold_d;
        end
    end

    assign link_tx_valid_o = (state_q == SEND);
    assign link_tx_chan_o  = grant_q;
    assign link_tx_data_o  = hold_q[grant_q];
    assign overrun_o       = overrun_q;

    // Import side
    logic [N_RX-1:0]   waiting_q, waiting_d;
    logic [TO_W-1:0]   cnt_q [N_RX];
    logic [TO_W-1:0]   cnt_d [N_RX];
    logic [N_RX*W-1:0] rx_data_q, rx_data_d;
    logic [N_RX-1:0]   upd_q, upd_d;
    logic [N_RX-1:0]   terr_q, terr_d;
    logic              stray_q, stray_d;
    logic [N_RX-1:0]   hit;

    always_comb begin
        waiting_d = waiting_q;
        cnt_d     = cnt_q;
        rx_data_d = rx_data_q;
        upd_d     = '0;
        terr_d    = terr_q;
        stray_d   = stray_q;
        hit       = '0;
        for (int j = 0; j < N_RX; j++) begin
            hit[j] = link_rx_valid_i && (int'(link_rx_chan_i) == j) && waiting_q[j];
            if (waiting_q[j]) begin
                cnt_d[j] = (cnt_q[j] == '1) ? cnt_q[j] : cnt_q[j] + 1'b1;
            end
            if (hit[j]) begin
                rx_data_d[j*W +: W] = link_rx_data_i;
                upd_d[j]            = 1'b1;
                waiting_d[j]        = 1'b0;
            end else if (waiting_q[j] && (timeout_i != '0) &&
                         (({1'b0, cnt_q[j]} + 1'b1) == {1'b0, timeout_i})) begin
                terr_d[j]    = 1'b1;
                waiting_d[j] = 1'b0;
            end
            if (rx_evt_i[j]) begin
                waiting_d[j] = 1'b1;
                cnt_d[j]     = '0;
            end
        end
        if (link_rx_valid_i && (hit == '0)) begin
            stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            waiting_q <= '0;
            rx_data_q <= '0;
            upd_q     <= '0;
            terr_q    <= '0;
            stray_q   <= 1'b0;
            for (int j = 0; j < N_RX; j++) begin
                cnt_q[j] <= '0;
            end
        end else begin
            waiting_q <= waiting_d;
            rx_data_q <= rx_data_d;
            upd_q     <= upd_d;
            terr_q    <= terr_d;
            stray_q   <= stray_d;
            cnt_q     <= cnt_d;
        end
    end

    assign link_rx_ready_o = 1'b1;
    assign freeze_clk_o    = waiting_q;
    assign rx_data_o       = rx_data_q;
    assign rx_upd_o        = upd_q;
    assign timeout_err_o   = terr_q;
    assign stray_o         = stray_q;

endmodule

// File: tb/tb_part_sync_bridge.sv
// Bench for part_sync_bridge: directed scenarios plus randomized export traffic against a queue-free capture model.
module tb_part_sync_bridge;

    localparam int N_TX = 3;
    localparam int N_RX = 1;
    localparam int W    = 9;
    localparam int TO_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_TX-1:0]   tx_evt;
    logic [N_TX*W-1:0] tx_data;
    logic [N_RX-1:0]   rx_evt;
    logic [TO_W-1:0]   timeout;
    logic              tx_valid;
    logic              tx_ready;
    logic [1:0]        tx_chan;
    logic [W-1:0]      tx_dat;
    logic              rx_valid;
    logic [0:0]        rx_chan;
    logic [W-1:0]      rx_dat;
    logic              rx_ready;
    logic [N_RX-1:0]   freeze;
    logic [N_RX*W-1:0] rx_out;
    logic [N_RX-1:0]   upd;
    logic [N_TX-1:0]   overrun;
    logic              stray;
    logic [N_RX-1:0]   terr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    part_sync_bridge #(.N_TX(N_TX), .N_RX(N_RX), .W(W), .TO_W(TO_W)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .tx_evt_i        (tx_evt),
        .tx_data_i       (tx_data),
        .rx_evt_i        (rx_evt),
        .timeout_i       (timeout),
        .link_tx_valid_o (tx_valid),
        .link_tx_ready_i (tx_ready),
        .link_tx_chan_o  (tx_chan),
        .link_tx_data_o  (tx_dat),
        .link_rx_valid_i (rx_valid),
        .link_rx_chan_i  (rx_chan),
        .link_rx_data_i  (rx_dat),
        .link_rx_ready_o (rx_ready),
        .freeze_clk_o    (freeze),
        .rx_data_o       (rx_out),
        .rx_upd_o        (upd),
        .overrun_o       (overrun),
        .stray_o         (stray),
        .timeout_err_o   (terr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tx_evt   = '0;
        rx_evt   = '0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        n_chk++;
        if (tx_valid !== 1'b0 || tx_chan !== 2'd0 || tx_dat !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_tx: valid=%b chan=%0d data=%h, want 0 0 000", tx_valid, tx_chan, tx_dat);
        end
        n_chk++;
        if (freeze !== 1'b0 || rx_out !== 9'h0 || upd !== 1'b0 || rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rx: freeze=%b rx_data=%h upd=%b rdy=%b, want 0 000 0 1", freeze, rx_out, upd, rx_ready);
        end
        n_chk++;
        if (overrun !== 3'b000 || stray !== 1'b0 || terr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ovr=%b stray=%b terr=%b, want 000 0 0", overrun, stray, terr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_export_burst();
        logic [W-1:0] exp_d [3];
        int           cyc [3];
        logic [1:0]   ch [3];
        logic [W-1:0] dd [3];
        int           nw;
        exp_d    = '{9'h101, 9'h0AA, 9'h155};
        nw       = 0;
        tx_data  = {9'h155, 9'h0AA, 9'h101};
        tx_evt   = 3'b111;
        tx_ready = 1'b1;
        step();
        tx_evt = '0;
        for (int c = 1; c <= 12; c++) begin
            if (tx_valid && nw < 3) begin
                cyc[nw] = c;
                ch[nw]  = tx_chan;
                dd[nw]  = tx_dat;
                nw++;
            end
            step();
        end
        n_chk++;
        if (nw != 3) begin
            n_fail++;
            $display("FAIL burst_count: got %0d words, want 3", nw);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (int'(ch[i]) != i || dd[i] !== exp_d[i] || cyc[i] != 2 + 2 * i) begin
                    n_fail++;
                    $display("FAIL burst_word%0d: chan=%0d data=%h cyc=%0d, want chan=%0d data=%h cyc=%0d",
                             i, ch[i], dd[i], cyc[i], i, exp_d[i], 2 + 2 * i);
                end
            end
        end
        n_chk++;
        if (overrun !== 3'b000) begin
            n_fail++;
            $display("FAIL burst_overrun: got %b, want 000", overrun);
        end
    endtask

    task automatic test_stall_overrun();
        tx_ready         = 1'b0;
        tx_data[W +: W]  = 9'h0A5;
        tx_evt           = 3'b010;
        step();
        tx_data[W +: W]  = 9'h15A;
        tx_evt           = 3'b010;
        step();
        tx_evt = '0;
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (tx_valid !== 1'b1 || tx_chan !== 2'd1 || tx_dat !== 9'h15A) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b chan=%0d data=%h, want 1 1 15a", i, tx_valid, tx_chan, tx_dat);
            end
            step();
        end
        n_chk++;
        if (overrun !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_overrun: got %b, want 010", overrun);
        end
        tx_ready = 1'b1;
        step();
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: valid=%b, want 0", tx_valid);
        end
        step();
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_no_resend: valid=%b chan=%0d, want 0", tx_valid, tx_chan);
        end
    endtask

    task automatic test_import();
        timeout = '0;
        rx_evt  = 1'b1;
        step();
        rx_evt = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            n_chk++;
            if (freeze !== 1'b1 || upd !== 1'b0) begin
                n_fail++;
                $display("FAIL import_wait_c%0d: freeze=%b upd=%b, want 1 0", c, freeze, upd);
            end
            if (c == 5) begin
                rx_valid = 1'b1;
                rx_chan  = 1'b0;
                rx_dat   = 9'h1FF;
            end
            step();
        end
        rx_valid = 1'b0;
        n_chk++;
        if (freeze !== 1'b0 || upd !== 1'b1 || rx_out !== 9'h1FF) begin
            n_fail++;
            $display("FAIL import_recv: freeze=%b upd=%b data=%h, want 0 1 1ff", freeze, upd, rx_out);
        end
        step();
        n_chk++;
        if (upd !== 1'b0 || rx_out !== 9'h1FF || stray !== 1'b0) begin
            n_fail++;
            $display("FAIL import_after: upd=%b data=%h stray=%b, want 0 1ff 0", upd, rx_out, stray);
        end
    endtask

    task automatic test_timeout();
        timeout = 16'd8;
        rx_evt  = 1'b1;
        step();
        rx_evt = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            n_chk++;
            if (freeze !== 1'b1 || terr !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_wait_c%0d: freeze=%b terr=%b, want 1 0", c, freeze, terr);
            end
            step();
        end
        n_chk++;
        if (freeze !== 1'b0 || terr !== 1'b1 || rx_out !== 9'h1FF || upd !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_fire: freeze=%b terr=%b data=%h upd=%b, want 0 1 1ff 0", freeze, terr, rx_out, upd);
        end
        timeout = '0;
    endtask

    task automatic test_stray();
        do_reset();
        rx_valid = 1'b1;
        rx_chan  = 1'b1;
        rx_dat   = 9'h077;
        step();
        rx_valid = 1'b0;
        n_chk++;
        if (stray !== 1'b1 || upd !== 1'b0 || rx_out !== 9'h0 || freeze !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_range: stray=%b upd=%b data=%h freeze=%b, want 1 0 000 0", stray, upd, rx_out, freeze);
        end
        do_reset();
        n_chk++;
        if (stray !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_cleared: stray=%b, want 0", stray);
        end
        rx_valid = 1'b1;
        rx_chan  = 1'b0;
        rx_dat   = 9'h088;
        step();
        rx_valid = 1'b0;
        n_chk++;
        if (stray !== 1'b1 || upd !== 1'b0 || rx_out !== 9'h0) begin
            n_fail++;
            $display("FAIL stray_idle: stray=%b upd=%b data=%h, want 1 0 000", stray, upd, rx_out);
        end
    endtask

    task automatic test_rx_simul();
        do_reset();
        timeout = 16'd8;
        rx_evt  = 1'b1;
        step();
        rx_evt = 1'b0;
        step();
        rx_evt   = 1'b1;
        rx_valid = 1'b1;
        rx_chan  = 1'b0;
        rx_dat   = 9'h0C3;
        step();
        rx_evt   = 1'b0;
        rx_valid = 1'b0;
        n_chk++;
        if (upd !== 1'b1 || rx_out !== 9'h0C3 || freeze !== 1'b1 || stray !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_recv: upd=%b data=%h freeze=%b stray=%b, want 1 0c3 1 0", upd, rx_out, freeze, stray);
        end
        for (int c = 3; c <= 10; c++) begin
            n_chk++;
            if (freeze !== 1'b1 || terr !== 1'b0) begin
                n_fail++;
                $display("FAIL simul_wait_c%0d: freeze=%b terr=%b, want 1 0", c, freeze, terr);
            end
            step();
        end
        n_chk++;
        if (freeze !== 1'b0 || terr !== 1'b1 || rx_out !== 9'h0C3) begin
            n_fail++;
            $display("FAIL simul_timeout: freeze=%b terr=%b data=%h, want 0 1 0c3", freeze, terr, rx_out);
        end
        timeout = '0;
    endtask

    task automatic test_random_export();
        logic [W-1:0]    mhold [N_TX];
        bit              mpend [N_TX];
        logic [N_TX-1:0] movr;
        logic [N_TX-1:0] ev;
        logic [W-1:0]    dv [N_TX];
        logic            rdy;
        bit              hs;
        bit              hs_k;
        int              words;
        do_reset();
        movr  = '0;
        words = 0;
        for (int k = 0; k < N_TX; k++) begin
            mhold[k] = '0;
            mpend[k] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            rdy = (cyc >= 500) ? 1'b1 : ($urandom_range(0, 2) != 0);
            ev  = '0;
            for (int k = 0; k < N_TX; k++) begin
                if (cyc < 500) ev[k] = ($urandom_range(0, 4) == 0);
                dv[k] = W'($urandom);
                tx_data[k*W +: W] = dv[k];
            end
            tx_evt   = ev;
            tx_ready = rdy;
            hs       = tx_valid && rdy;
            if (hs) begin
                words++;
                n_chk++;
                if (!mpend[tx_chan] || tx_dat !== mhold[tx_chan]) begin
                    n_fail++;
                    $display("FAIL rand_word cyc=%0d: chan=%0d data=%h, want pending chan with data %h",
                             cyc, tx_chan, tx_dat, mhold[tx_chan]);
                end
            end
            for (int k = 0; k < N_TX; k++) begin
                hs_k = hs && (int'(tx_chan) == k);
                if (ev[k]) begin
                    if (mpend[k] && !hs_k) movr[k] = 1'b1;
                    mhold[k] = dv[k];
                    mpend[k] = 1'b1;
                end else if (hs_k) begin
                    mpend[k] = 1'b0;
                end
            end
            step();
            n_chk++;
            if (overrun !== movr) begin
                n_fail++;
                $display("FAIL rand_overrun cyc=%0d: got %b, want %b", cyc, overrun, movr);
            end
        end
        tx_evt = '0;
        n_chk++;
        if (tx_valid !== 1'b0 || words == 0 || mpend[0] || mpend[1] || mpend[2]) begin
            n_fail++;
            $display("FAIL rand_drain: valid=%b words=%0d pend=%b%b%b, want 0 >0 000",
                     tx_valid, words, mpend[2], mpend[1], mpend[0]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tx_ready            = 1'b0;
        tx_data[2*W +: W]   = 9'h011;
        tx_evt              = 3'b100;
        step();
        tx_data[2*W +: W]   = 9'h022;
        step();
        tx_evt = '0;
        rx_evt = 1'b1;
        step();
        rx_evt   = 1'b0;
        rx_valid = 1'b1;
        rx_chan  = 1'b1;
        step();
        rx_valid = 1'b0;
        n_chk++;
        if (tx_valid !== 1'b1 || freeze !== 1'b1 || stray !== 1'b1 || overrun !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_setup: valid=%b freeze=%b stray=%b ovr=%b, want 1 1 1 100", tx_valid, freeze, stray, overrun);
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (tx_valid !== 1'b0 || freeze !== 1'b0 || stray !== 1'b0 || overrun !== 3'b000 || terr !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: valid=%b freeze=%b stray=%b ovr=%b terr=%b, want all 0",
                     tx_valid, freeze, stray, overrun, terr);
        end
        step();
        rst               = 1'b0;
        tx_ready          = 1'b1;
        tx_data[0 +: W]   = 9'h033;
        tx_evt            = 3'b001;
        step();
        tx_evt = '0;
        n_chk++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_resume_c1: valid=%b, want 0", tx_valid);
        end
        step();
        n_chk++;
        if (tx_valid !== 1'b1 || tx_chan !== 2'd0 || tx_dat !== 9'h033) begin
            n_fail++;
            $display("FAIL mid_resume_c2: valid=%b chan=%0d data=%h, want 1 0 033", tx_valid, tx_chan, tx_dat);
        end
        step();
    endtask

    initial begin
        rst      = 1'b1;
        tx_evt   = '0;
        tx_data  = '0;
        rx_evt   = '0;
        timeout  = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_chan  = '0;
        rx_dat   = '0;
        test_reset();
        test_export_burst();
        test_stall_overrun();
        test_import();
        test_timeout();
        test_stray();
        test_rx_simul();
        test_random_export();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
